// File: rtl/riscv_defs.sv
// Shared widths, the NOP encoding and loader FSM states for the instruction memory slice.
package riscv_defs;

  localparam int unsigned NB_ADDR = 32;
  localparam int unsigned NB_WORD = 32;

  localparam logic [NB_WORD-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    LOAD,
    RUN
  } imem_ld_state_t;

endpackage

// File: rtl/imem_if.sv
// CPU <-> instruction memory fetch port: the CPU drives the pc, the memory returns the word.
interface imem_if;
  import riscv_defs::*;

  logic [NB_ADDR-1:0] imem_pc;
  logic [NB_WORD-1:0] imem_instruction;

  modport cpu (
    output imem_pc,
    input  imem_instruction
  );

  modport memory (
    input  imem_pc,
    output imem_instruction
  );

endinterface

// File: rtl/imem_ram.sv
// Word-wide instruction storage: one synchronous read port, one write port, no reset on contents.
module imem_ram
  import riscv_defs::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [NB_WORD-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [NB_WORD-1:0] rdata
);

  logic [NB_WORD-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory while holding the CPU, then serves fetches.
// Optional IMEM_ALIGN_CHECK_EN: flag misaligned RUN fetches and return a NOP for them.
module imem_loader
  import riscv_defs::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  imem_if.memory        imem,
  input  logic          load_req,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          cpu_hold,
  output logic          ld_overflow,
  output logic          imem_misalign
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0]        PTR_FULL  = PW'(DEPTH);
  localparam logic [NB_ADDR-3:0]   IDX_LIMIT = (NB_ADDR-2)'(DEPTH);

  imem_ld_state_t     state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [NB_WORD-1:0] asm_q, asm_d;
  logic               ovf_q, ovf_d;
  logic               nop_q, nop_d;
  logic               misalign_d;
  logic               we;
  logic [NB_WORD-1:0] wdata;
  logic [NB_WORD-1:0] rdata;
  logic [NB_ADDR-3:0] fetch_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      nop_q   <= nop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    // Bytes above the current one are still zero, so a short final word is zero-padded.
    wdata   = asm_q | (NB_WORD'(ld_data) << {cnt_q, 3'b000});
    unique case (state_q)
      LOAD: begin
        if (ld_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3 || ld_last) begin
            asm_d = '0;
            // Pointer saturates at DEPTH so an oversized image never wraps onto word 0.
            if (ptr_q == PTR_FULL) begin
              ovf_d = 1'b1;
            end else begin
              we    = 1'b1;
              ptr_d = ptr_q + PW'(1);
            end
          end else begin
            asm_d = wdata;
          end
          if (ld_last) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (load_req) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign fetch_idx = imem.imem_pc[NB_ADDR-1:2];

  always_comb begin
    misalign_d = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
    misalign_d = (state_q == RUN) && (imem.imem_pc[1:0] != 2'b00);
`endif
    nop_d = (state_q == LOAD) || (fetch_idx >= IDX_LIMIT) || misalign_d;
  end

`ifdef IMEM_ALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign imem_misalign = misalign_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^imem.imem_pc[1:0];
  assign imem_misalign = 1'b0;
`endif

  imem_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(ptr_q[AW-1:0]),
    .wdata(wdata),
    .raddr(imem.imem_pc[AW+1:2]),
    .rdata(rdata)
  );

  assign imem.imem_instruction = nop_q ? NOP_INSTR : rdata;
  assign ld_ready    = rst || (state_q == LOAD);
  assign cpu_hold    = rst || (state_q == LOAD);
  assign ld_overflow = ovf_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem  imem_if.memory  bundle  responder end; samples imem_pc (NB_ADDR), drives imem_instruction (NB_WORD).
REQ-005 SHALL have port load_req  input  1  pulse requesting a new program load.
REQ-006 SHALL have port ld_valid  input  1  loader byte valid.
REQ-007 SHALL have port ld_data  input  8  loader byte.
REQ-008 SHALL have port ld_last  input  1  marks final byte of the image; qualified by ld_valid.
REQ-009 SHALL have port ld_ready  output  1  loader byte accepted when ld_valid && ld_ready.
REQ-010 SHALL have port cpu_hold  output  1  CPU stall while image is not loaded.
REQ-011 SHALL have port ld_overflow  output  1  sticky flag for an image larger than DEPTH words.
REQ-012 SHALL have port imem_misalign  output  1  misaligned fetch flag (see Configuration).

Function
REQ-013 SHALL implement the states LOAD and RUN.
REQ-014 LOAD -> RUN SHALL occur on the edge that accepts a byte with ld_last=1.
REQ-015 RUN -> LOAD SHALL occur on load_req=1.
- Entering LOAD clears the word pointer, byte counter and ld_overflow.
- load_req while in LOAD is ignored.
REQ-016 ld_ready SHALL equal (state==LOAD); cpu_hold SHALL equal (state==LOAD).
REQ-017 Accepted bytes SHALL be assembled little-endian.
- Byte k (k=0..3) lands in bits [8k+7:8k].
- A 2-bit counter wraps 3->0.
- The word is written at the word pointer when k==3; the pointer then increments.
REQ-018 ld_last accepted with k<3 SHALL write the partial word, upper bytes zero.
REQ-019 A write with word pointer >= DEPTH SHALL be dropped and SHALL set ld_overflow, held until the next LOAD entry.
REQ-020 Fetch SHALL be synchronous: imem_instruction at cycle N+1 = mem[imem_pc[NB_ADDR-1:2]] for imem_pc sampled at cycle N in RUN.
REQ-021 Fetch SHALL return NOP_INSTR (0x00000013) in any of these cases:
- the sampled cycle is in LOAD;
- the word index is >= DEPTH.
REQ-022 Memory contents SHALL persist across reset and across RUN->LOAD; only rewritten words change.

Reset
REQ-023 While rst=1, the block SHALL apply these values:
- state <= LOAD;
- word pointer and byte counter <= 0;
- ld_overflow <= 0;
- imem_instruction <= 0x00000013;
- imem_misalign <= 0.
- Combinational outputs take their LOAD values: ld_ready=1, cpu_hold=1.
REQ-024 rst asserted mid-load SHALL discard any partial word; bytes already written SHALL remain in memory.

Configuration
REQ-025 With IMEM_ALIGN_CHECK_EN defined, a RUN fetch with imem_pc[1:0]!=0 SHALL register imem_misalign=1 and imem_instruction=0x00000013 in the same cycle.
REQ-026 Without IMEM_ALIGN_CHECK_EN, imem_pc[1:0] SHALL be ignored and imem_misalign SHALL be tied 0.

Structure
REQ-027 riscv_defs SHALL hold NB_ADDR, NB_WORD, NOP_INSTR and the enum imem_ld_state_t {LOAD, RUN}.
REQ-028 The storage array with its synchronous read port and single write port SHALL be the sub-module imem_ram; the FSM and byte assembly stay in imem_loader.

Verification
REQ-029 Load scenario: reset, then stream bytes 13 00 00 00 93 00 10 00 (last on 8th).
- Required: RUN entered next cycle.
- Required: pc=0 -> 0x00000013 and pc=4 -> 0x00100093, each one cycle later.
REQ-030 Partial-word scenario: load bytes AA BB CC with ld_last on CC.
- Required: pc=0 fetch = 0x00CCBBAA.
REQ-031 Overflow scenario: DEPTH=4, stream 20 bytes.
- Required: ld_overflow=1.
- Required: words 0-3 correct; no wrap overwrite of word 0.
REQ-032 Hold scenario: in RUN, pulse load_req.
- Required: cpu_hold=1 and ld_ready=1 next cycle.
- Required: fetches return 0x00000013 until reload completes.
- Required: old words not rewritten persist.
REQ-033 Mid-load reset scenario: rst after 2 bytes of word 1.
- Required: word 0 retained; pointer restarts at 0.
REQ-034 Misalign scenario (IMEM_ALIGN_CHECK_EN): pc=0x2 in RUN.
- Required: imem_misalign=1 and imem_instruction=0x00000013 next cycle.
- Without the macro: imem_misalign=0 and the word-0 contents are fetched.
